// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file (x1..x31, x0 hard-wired to zero) with a per-register
//   pending-write counter. The operand-read stage uses the two combinational
//   read ports; a source is valid when no write to it is outstanding, or when
//   the only outstanding write is landing this cycle (bypass build).
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : writeback data is forwarded to the read ports on an address
//                 match, and a matching last-pending writeback makes the read
//                 valid in the same cycle.
//     undefined : no forwarding; a dependent read becomes valid one cycle
//                 after its writeback.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop all outstanding reservations
//   r1_addr/r1_valid/r1_data, r2_addr/r2_valid/r2_data   read ports
//   issue_en/issue_dest   reserve a destination; issue_ready = not saturated
//   wb_en/wb_dest/wb_data one writeback per cycle
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [4:0]  r1_addr,
    output logic        r1_valid,
    output logic [31:0] r1_data,
    input  logic [4:0]  r2_addr,
    output logic        r2_valid,
    output logic [31:0] r2_data,
    input  logic        issue_en,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    // Entry 0 is reset to zero and never written, so it reads as zero.
    logic [31:0]             r_rf [32];
    logic [31:0][PEND_W-1:0] w_cnt;

    // ------------------------------------------------------------------
    // Register storage. Writeback lands even during flush: the producing
    // instruction was older than the flush point.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (wb_en && wb_dest != 5'd0) begin
            r_rf[wb_dest] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write counters, one per architectural register 1..31.
    // ------------------------------------------------------------------
    assign w_cnt[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        logic [PEND_W-1:0] r_cnt;
        logic              w_inc;
        logic              w_dec;

        assign w_inc    = issue_en && (issue_dest == 5'(g));
        // A writeback to an idle register must not underflow the counter.
        assign w_dec    = wb_en && (wb_dest == 5'(g)) && (r_cnt != '0);
        assign w_cnt[g] = r_cnt;

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                // Saturate rather than wrap if the issuer ignores issue_ready.
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. A same-cycle issue to the read address is deliberately
    // ignored: the issuer is younger than (or is) the reader.
    // ------------------------------------------------------------------
    logic w_hit1;
    logic w_hit2;

`ifdef WB_BYPASS_EN
    assign w_hit1 = wb_en && (wb_dest == r1_addr) && (r1_addr != 5'd0);
    assign w_hit2 = wb_en && (wb_dest == r2_addr) && (r2_addr != 5'd0);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    always_comb begin
        r1_valid = (r1_addr == 5'd0) || (w_cnt[r1_addr] == '0) ||
                   (w_hit1 && w_cnt[r1_addr] == CNT_ONE);
        r1_data  = (r1_addr == 5'd0) ? 32'd0 :
                   w_hit1            ? wb_data : r_rf[r1_addr];
        r2_valid = (r2_addr == 5'd0) || (w_cnt[r2_addr] == '0) ||
                   (w_hit2 && w_cnt[r2_addr] == CNT_ONE);
        r2_data  = (r2_addr == 5'd0) ? 32'd0 :
                   w_hit2            ? wb_data : r_rf[r2_addr];
    end

    assign issue_ready = (issue_dest == 5'd0) || (w_cnt[issue_dest] != CNT_MAX);

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    localparam int PEND_W  = 2;
    localparam int CNT_MAX = (1 << PEND_W) - 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  r1_addr = '0, r2_addr = '0;
    logic        r1_valid, r2_valid;
    logic [31:0] r1_data, r2_data;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        issue_ready;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_data = '0;

    regfile_scoreboard #(.PEND_W(PEND_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .r1_addr(r1_addr), .r1_valid(r1_valid), .r1_data(r1_data),
        .r2_addr(r2_addr), .r2_valid(r2_valid), .r2_data(r2_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // Reference model: architectural values and outstanding write counts.
    int          m_cnt [32];
    logic [31:0] m_rf  [32];

    typedef struct {
        int          cyc;
        logic        v1;
        logic [31:0] d1;
        logic        v2;
        logic [31:0] d2;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    // Commit the inputs that the just-passed clock edge sampled.
    task automatic model_commit();
        int dst;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i] = 0;
                m_rf[i]  = '0;
            end
            return;
        end
        if (wb_en && wb_dest != 0) m_rf[wb_dest] = wb_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            return;
        end
        if (wb_en && wb_dest != 0 && m_cnt[wb_dest] > 0) m_cnt[wb_dest] -= 1;
        if (issue_en && issue_dest != 0) begin
            dst = issue_dest;
            m_cnt[dst] = (m_cnt[dst] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[dst] + 1;
        end
    endtask

    function automatic logic exp_valid(input logic [4:0] a);
        if (a == 0) return 1'b1;
        if (m_cnt[a] == 0) return 1'b1;
        return BYP && wb_en && wb_dest == a && m_cnt[a] == 1;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (BYP && wb_en && wb_dest == a) return wb_data;
        return m_rf[a];
    endfunction

    // One cycle: model absorbs the edge, then new inputs are applied and the
    // expected combinational response is queued for the monitor.
    task automatic drive(input logic rst, input logic fl,
                         input logic ie, input logic [4:0] id,
                         input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
        reset = rst; flush = fl;
        issue_en = ie; issue_dest = id;
        wb_en = we; wb_dest = wd; wb_data = wdat;
        r1_addr = a1; r2_addr = a2;
        e.cyc = cyc;
        e.v1  = exp_valid(a1);
        e.d1  = exp_data(a1);
        e.v2  = exp_valid(a2);
        e.d2  = exp_data(a2);
        e.rdy = (id == 0) || (m_cnt[id] < CNT_MAX);
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    // Monitor: the outputs are combinational, so every cycle presents one
    // response; compare it against the oldest queued expectation.
    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, c, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("r1_valid",    e.cyc, 32'(r1_valid),    32'(e.v1));
            chk("r1_data",     e.cyc, r1_data,          e.d1);
            chk("r2_valid",    e.cyc, 32'(r2_valid),    32'(e.v2));
            chk("r2_data",     e.cyc, r2_data,          e.d2);
            chk("issue_ready", e.cyc, 32'(issue_ready), 32'(e.rdy));
        end
    end

    initial begin
        logic [4:0]  id, wd, a1, a2;
        logic        ie, we, rst, fl;
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = 0;
            m_rf[i]  = '0;
        end

        // Reset, then reads of 5 and 0 straight out of reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 5, 0, 0, 0, 5, 0);

        // Reserve 3, observe pending, writeback DEADBEEF, observe result.
        drive(0, 0, 1, 3, 0, 0, 0, 3, 0);
        drive(0, 0, 0, 3, 0, 0, 0, 3, 3);
        drive(0, 0, 0, 3, 1, 3, 32'hDEADBEEF, 3, 0);
        idle(3, 3);

        // Two outstanding writes to 7: first writeback forwards but stays pending.
        drive(0, 0, 1, 7, 0, 0, 0, 7, 0);
        drive(0, 0, 1, 7, 0, 0, 0, 7, 0);
        drive(0, 0, 0, 7, 1, 7, 32'h11, 7, 7);
        idle(7, 0);
        drive(0, 0, 0, 7, 1, 7, 32'h22, 7, 7);
        idle(7, 0);

        // Saturate 9, check issue_ready, drain one.
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 9, 0, 0, 0, 9, 0);
        drive(0, 0, 0, 9, 0, 0, 0, 9, 0);
        drive(0, 0, 0, 9, 1, 9, 32'h99, 9, 0);
        drive(0, 0, 0, 9, 0, 0, 0, 9, 0);

        // cnt[4]=1, then simultaneous issue+writeback keeps it at 1.
        drive(0, 0, 1, 4, 0, 0, 0, 4, 0);
        drive(0, 0, 1, 4, 1, 4, 32'h4444, 4, 0);
        idle(4, 4);

        // Flush with writeback in the same cycle.
        drive(0, 0, 1, 12, 0, 0, 0, 12, 0);
        drive(0, 1, 0, 12, 1, 12, 32'h55, 12, 9);
        idle(12, 9);

        // Register 0 ignores issue and writeback.
        drive(0, 0, 1, 0, 1, 0, 32'hFF, 0, 0);
        idle(0, 0);

        // Writeback to an idle register: no underflow.
        drive(0, 0, 0, 0, 1, 20, 32'h2020, 20, 0);
        drive(0, 0, 1, 20, 0, 0, 0, 20, 0);
        idle(20, 0);

        // Reset mid-operation drops the same-cycle writeback.
        drive(0, 0, 1, 6, 0, 0, 0, 6, 0);
        drive(1, 0, 0, 0, 1, 6, 32'h6666, 6, 3);
        idle(6, 3);

        // Random traffic over a small register window to force collisions.
        for (int n = 0; n < 1500; n++) begin
            id  = 5'($urandom_range(0, 7));
            wd  = 5'($urandom_range(0, 7));
            a1  = 5'($urandom_range(0, 7));
            a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            we  = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 49) == 0);
            // Issue only when the reference says the destination has room.
            ie  = ($urandom_range(0, 2) != 0);
            drive(rst, fl, ie, id, we, wd, $urandom, a1, a2);
            if (issue_en && issue_dest != 0 && m_cnt[issue_dest] >= CNT_MAX) begin
                issue_en = 1'b0;
                exp_q[exp_q.size()-1].rdy = 1'b0;
            end
        end
        idle(0, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file plus per-register pending-write scoreboard.
- Serves the operand-read stage: two combinational read ports, each returning data and a valid flag (source not awaiting writeback).
- Accepts destination reservations at issue and one writeback per cycle.
- Clears all reservations on pipeline flush.

Parameters:
- PEND_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  pipeline flush; discards all outstanding reservations
- r1_addr  input  5  read port 1 register index
- r1_valid  output  1  r1_data is final (no pending write, or bypassed)
- r1_data  output  32  read port 1 data
- r2_addr  input  5  read port 2 register index
- r2_valid  output  1  as r1_valid for port 2
- r2_data  output  32  read port 2 data
- issue_en  input  1  reserve issue_dest this cycle (instruction leaves read-operands stage)
- issue_dest  input  5  destination to reserve
- issue_ready  output  1  issue_dest counter not saturated; issuer must not assert issue_en when low
- wb_en  input  1  writeback valid
- wb_dest  input  5  writeback register index
- wb_data  input  32  writeback data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clk.
- Storage: rf[1..31] 32-bit; cnt[1..31] PEND_W-bit. Register 0 has no storage: reads return 0 with valid=1; issue and writeback to 0 are ignored.
- Reset: all cnt=0, all rf=0. So after reset every rN_valid=1, rN_data=0, issue_ready=1.
- Read ports are purely combinational, zero latency, from the current-cycle addr.
  - Define hit = wb_en && wb_dest==addr && addr!=0.
  - valid = (addr==0) || cnt[addr]==0 || (hit && cnt[addr]==1).
  - data = addr==0 ? 0 : hit ? wb_data : rf[addr].
  - Writeback data is always forwarded on an address match, even if cnt>1.
- A same-cycle issue_en to the read address does not affect the read result; the issuer is younger or is the reader itself.
- Writeback: on posedge with wb_en && wb_dest!=0, rf[wb_dest] <= wb_data. This applies regardless of flush.
- Counter update for register d (evaluated per register, posedge), where inc = issue_en && issue_dest==d and dec = wb_en && wb_dest==d && cnt[d]!=0:
  - flush: cnt <= 0 (overrides inc/dec).
  - inc && !dec: cnt+1.
  - dec && !inc: cnt-1.
  - inc && dec: unchanged.
  - Writeback to a register with cnt==0: data written, counter stays 0 (no underflow).
- issue_ready = (issue_dest==0) || cnt[issue_dest] != 2^PEND_W-1. Combinational.
- Issue with issue_ready low: counter stays saturated (no wrap). Verification flags this as a protocol error.
- reset has priority over flush; flush has priority over issue/wb counter changes.
- Reset mid-operation: in-flight state discarded; the same cycle's wb data is not written.

Optional Feature:
- WB_BYPASS_EN. When defined, the writeback-to-read forwarding above is present.
- When undefined, hit is forced to 0:
  - valid = (addr==0) || cnt[addr]==0.
  - data = rf[addr].
  - A dependent read becomes valid one cycle after writeback.
  - Saves a 32-bit mux per port at one cycle of extra dependency latency.

Test Plan:
- Reset then read r1_addr=5, r2_addr=0 -> r1_valid=1, r1_data=0, r2_valid=1, r2_data=0; issue_ready=1.
- Issue dest=3 at cycle 0; read 3 at cycle 1 -> valid=0. At cycle 2, wb_en dest=3 data=0xDEADBEEF:
  - with WB_BYPASS_EN, same cycle valid=1 and data=0xDEADBEEF;
  - without it, valid=1 and data=0xDEADBEEF at cycle 3.
- Issue dest=7 twice (cnt=2); wb dest=7 data=0x11 -> read 7 gives valid=0 (cnt becomes 1) with data=0x11 forwarded. A second wb of 0x22 -> valid=1, data=0x22.
- With PEND_W=2, issue dest=9 three times -> issue_ready=0 when issue_dest=9; wb dest=9 -> next cycle issue_ready=1.
- Issue dest=4 and wb dest=4 in the same cycle with cnt=1 -> cnt stays 1, valid=0 next cycle, rf[4] updated.
- Issue dest=12, then flush with wb dest=12 data=0x55 in the same cycle -> next cycle valid=1, data=0x55, cnt=0.
- Issue dest=0 and wb dest=0 data=0xFF -> r0 reads 0, valid=1.
